// File: rtl/chan_mux_rr_if.sv
// Channel mux bus: per-channel valid/ready inputs, one registered output.
// Both modports share the same signal set; only the direction differs.
interface chan_mux_rr_if #(
  parameter int NCH  = 8,
  parameter int W    = 8,
  parameter int SELW = $clog2(NCH)
);
  logic              mode;
  logic [SELW-1:0]   sel;
  logic [NCH-1:0]    in_valid;
  logic [NCH*W-1:0]  in_data;
  logic [NCH-1:0]    in_ready;
  logic              out_valid;
  logic [W-1:0]      out_data;
  logic [SELW-1:0]   out_ch;
  logic              out_ready;

  modport master (
    output mode, sel, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ch
  );

  modport slave (
    input  mode, sel, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );
endinterface

// File: rtl/chan_mux_rr.sv
// N-channel registered mux with direct-select and round-robin modes.
// A single output register decouples the sources from the consumer.
module chan_mux_rr #(
  parameter int NCH  = 8,
  parameter int W    = 8,
  parameter int SELW = $clog2(NCH)
) (
  input  logic          clk,
  input  logic          rst_n,
  chan_mux_rr_if.slave  bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  localparam logic [SELW:0]   NCH_W = (SELW+1)'(NCH);
  localparam logic [SELW-1:0] LAST  = SELW'(NCH-1);

  state_e          state_q, state_d;
  logic [W-1:0]    out_data_q, out_data_d;
  logic [SELW-1:0] out_ch_q, out_ch_d;
  logic [SELW-1:0] rr_ptr_q, rr_ptr_d;

  logic            load_ok;
  logic            accept;
  logic            gnt_vld;
  logic [SELW-1:0] gnt_idx;
  logic [SELW:0]   scan;
  logic [W-1:0]    word;
  logic [NCH-1:0]  rdy;

  // Grant: direct index, or first valid channel scanning up from rr_ptr.
  // The descending loop lets the earliest channel in scan order win.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    scan    = '0;
    if (bus.mode) begin
      for (int k = NCH-1; k >= 0; k--) begin
        scan = {1'b0, rr_ptr_q} + (SELW+1)'(k);
        if (scan >= NCH_W)
          scan = scan - NCH_W;
        if (bus.in_valid[scan[SELW-1:0]]) begin
          gnt_vld = 1'b1;
          gnt_idx = scan[SELW-1:0];
        end
      end
    end else if ({1'b0, bus.sel} < NCH_W) begin
      if (bus.in_valid[bus.sel]) begin
        gnt_vld = 1'b1;
        gnt_idx = bus.sel;
      end
    end
  end

  // Select the granted channel's data word.
  always_comb begin
    word = '0;
    for (int i = 0; i < NCH; i++)
      if (gnt_idx == SELW'(i))
        word = bus.in_data[i*W +: W];
  end

  // Handshake: load when empty or draining; rdy is one-hot or zero.
  always_comb begin
    load_ok = rst_n & ((state_q == EMPTY) | bus.out_ready);
    accept  = load_ok & gnt_vld;
    rdy     = '0;
    if (accept)
      rdy[gnt_idx] = 1'b1;
  end

  // Next state for the output register and round-robin pointer.
  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    out_ch_d   = out_ch_q;
    rr_ptr_d   = rr_ptr_q;
    unique case (state_q)
      EMPTY: if (accept) state_d = FULL;
      FULL:  if (!accept && bus.out_ready) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
    if (accept) begin
      out_data_d = word;
      out_ch_d   = gnt_idx;
      if (bus.mode)
        rr_ptr_d = (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;
    end
  end

  // State registers; reset discards any held word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      out_data_q <= '0;
      out_ch_q   <= '0;
      rr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      out_ch_q   <= out_ch_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign bus.in_ready  = rdy;
  assign bus.out_valid = (state_q == FULL);
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;

endmodule

// File: tb/tb_chan_mux_rr.sv
// Directed bench for chan_mux_rr with an expected-word queue.
// An 8-channel and a 6-channel instance share clock and reset.
module tb_chan_mux_rr;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  chan_mux_rr_if #(.NCH(8), .W(8)) b8 ();
  chan_mux_rr_if #(.NCH(6), .W(8)) b6 ();

  chan_mux_rr #(.NCH(8), .W(8)) u8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b8)
  );

  chan_mux_rr #(.NCH(6), .W(8)) u6 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b6)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [10:0] exp_q [$];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs are already driven. Check in_ready mid-cycle, move the
  // scoreboard across the edge, then check the output register.
  task automatic step(input logic [7:0] erdy,
                      input bit         push,
                      input logic [2:0] ch,
                      input logic [7:0] d,
                      input string      tag);
    #3;
    chk({tag, ":in_ready"}, 32'(b8.in_ready), 32'(erdy));
    @(posedge clk);
    if (exp_q.size() > 0 && b8.out_ready)
      void'(exp_q.pop_front());
    if (push)
      exp_q.push_back({ch, d});
    #1;
    chk({tag, ":out_valid"}, 32'(b8.out_valid),
        32'(exp_q.size() > 0));
    if (exp_q.size() > 0) begin
      chk({tag, ":out_ch"}, 32'(b8.out_ch), 32'(exp_q[0][10:8]));
      chk({tag, ":out_data"}, 32'(b8.out_data), 32'(exp_q[0][7:0]));
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    b8.mode      = 1'b0;
    b8.sel       = '0;
    b8.in_valid  = '1;
    b8.out_ready = 1'b1;
    for (int i = 0; i < 8; i++)
      b8.in_data[i*8 +: 8] = 8'hA0 + 8'(i);
    b6.mode      = 1'b0;
    b6.sel       = '0;
    b6.in_valid  = '0;
    b6.out_ready = 1'b1;
    for (int i = 0; i < 6; i++)
      b6.in_data[i*8 +: 8] = 8'hB0 + 8'(i);

    #1;
    chk("rst:out_valid", 32'(b8.out_valid), 32'd0);
    chk("rst:out_data", 32'(b8.out_data), 32'd0);
    chk("rst:out_ch", 32'(b8.out_ch), 32'd0);
    chk("rst:in_ready", 32'(b8.in_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_held:in_ready", 32'(b8.in_ready), 32'd0);
    chk("rst_held:out_valid", 32'(b8.out_valid), 32'd0);
    rst_n       = 1'b1;
    b8.in_valid = '0;

    // direct sweep
    for (int s = 0; s < 8; s++) begin
      b8.sel      = 3'(s);
      b8.in_valid = 8'd1 << s;
      step(8'd1 << s, 1'b1, 3'(s), 8'hA0 + 8'(s), "t2");
    end
    b8.in_valid = '0;
    step(8'h00, 1'b0, 3'd0, 8'h00, "t2_idle");

    // round-robin fairness, rr_ptr starts at 0
    b8.mode     = 1'b1;
    b8.in_valid = '1;
    for (int k = 0; k < 10; k++)
      step(8'd1 << (k % 8), 1'b1, 3'(k % 8),
           8'hA0 + 8'(k % 8), "t3");
    b8.in_valid = '0;
    step(8'h00, 1'b0, 3'd0, 8'h00, "t3_idle");

    // skip idle: accept ch2 alone to put rr_ptr at 3
    b8.in_valid = 8'b0000_0100;
    step(8'h04, 1'b1, 3'd2, 8'hA2, "t4_pre");
    b8.in_valid = 8'b1000_0100;
    step(8'h80, 1'b1, 3'd7, 8'hA7, "t4_ch7");
    step(8'h04, 1'b1, 3'd2, 8'hA2, "t4_ch2");
    b8.in_valid = '0;
    step(8'h00, 1'b0, 3'd0, 8'h00, "t4_idle");

    // backpressure: rr_ptr=3, only ch0 valid -> ch0, rr_ptr=1
    b8.in_valid = 8'b0000_0001;
    step(8'h01, 1'b1, 3'd0, 8'hA0, "t5_load");
    b8.out_ready = 1'b0;
    b8.in_valid  = '1;
    for (int k = 0; k < 4; k++)
      step(8'h00, 1'b0, 3'd0, 8'h00, "t5_hold");
    b8.out_ready = 1'b1;
    step(8'h02, 1'b1, 3'd1, 8'hA1, "t5_drain");
    b8.in_valid = '0;
    step(8'h00, 1'b0, 3'd0, 8'h00, "t5_idle");

    // reset mid-transfer with a held word; rr_ptr is 2 here
    b8.mode      = 1'b0;
    b8.sel       = 3'd3;
    b8.in_valid  = 8'b0000_1000;
    b8.out_ready = 1'b0;
    step(8'h08, 1'b1, 3'd3, 8'hA3, "t1_load");
    #2;
    rst_n = 1'b0;
    #1;
    chk("t1:out_valid", 32'(b8.out_valid), 32'd0);
    chk("t1:out_data", 32'(b8.out_data), 32'd0);
    chk("t1:out_ch", 32'(b8.out_ch), 32'd0);
    chk("t1:in_ready", 32'(b8.in_ready), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n        = 1'b1;
    b8.mode      = 1'b1;
    b8.in_valid  = '1;
    b8.out_ready = 1'b1;
    step(8'h01, 1'b1, 3'd0, 8'hA0, "t1_rrptr");
    b8.in_valid = '0;
    step(8'h00, 1'b0, 3'd0, 8'h00, "t1_idle");

    // six-channel build: out-of-range select
    b6.mode     = 1'b0;
    b6.sel      = 3'd7;
    b6.in_valid = '1;
    #3;
    chk("t6:in_ready", 32'(b6.in_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("t6:out_valid", 32'(b6.out_valid), 32'd0);
    b6.sel = 3'd5;
    #3;
    chk("t6_sel5:in_ready", 32'(b6.in_ready), 32'h20);
    @(posedge clk);
    #1;
    chk("t6_sel5:out_valid", 32'(b6.out_valid), 32'd1);
    chk("t6_sel5:out_ch", 32'(b6.out_ch), 32'd5);
    chk("t6_sel5:out_data", 32'(b6.out_data), 32'hB5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
